// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : sync_fifo_pkg                                                  |
// | Purpose   : Shared types and helpers for the parametrised synchronous FIFO.|
// |             Holds the status-flag bundle, its reset value, the occupancy   |
// |             counter width helper and the count-to-flags helper.            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package sync_fifo_pkg;

  localparam int FIFO_MIN_DEPTH = 4;

  // Status flag bundle, registered as one unit inside the FIFO.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FIFO_FLAGS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic fifo_flags_t fifo_flags_from_count(input int cnt, input int depth,
                                                        input int af_level, input int ae_level);
    fifo_flags_t f;
    f.full         = (cnt == depth);
    f.empty        = (cnt == 0);
    f.almost_full  = (cnt >= af_level);
    f.almost_empty = (cnt <= ae_level);
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_dp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fifo_dp_ram                                                    |
// | Purpose   : DEPTH x DATA_W storage for sync_fifo_param. One synchronous    |
// |             write port, one asynchronous read port. Contents not reset.    |
// | Ports     : clk      in  clock                                             |
// |             wr_en    in  write strobe                                      |
// |             wr_addr  in  write address                                     |
// |             wr_data  in  write data                                        |
// |             rd_addr  in  read address                                      |
// |             rd_data  out read data (combinational from rd_addr)            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module fifo_dp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Reading the pre-edge contents lets a full FIFO read and overwrite the
  // same slot in one cycle.
  assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : sync_fifo_param                                                |
// | Purpose   : Parametrised single-clock FIFO with simultaneous read/write,   |
// |             occupancy count, almost-full/almost-empty thresholds and       |
// |             registered overflow/underflow pulses.                          |
// | Config    : SYNC_FIFO_FWFT_EN defined -> first-word-fall-through output;   |
// |             undefined -> standard mode, 1-cycle registered read.           |
// | Ports     : clk, rst (sync, active-high)                                   |
// |             wr_en/din           write request and data                     |
// |             rd_en               read request / pop acknowledge (FWFT)      |
// |             dout/dout_valid     read data and valid                        |
// |             full/empty/almost_full/almost_empty  registered status flags   |
// |             count               occupancy 0..DEPTH                         |
// |             overflow/underflow  1-cycle pulses for rejected requests       |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             din,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  if (DATA_W < 1) begin : g_chk_data_w
    $error("sync_fifo_param: DATA_W must be >= 1");
  end
  if ((DEPTH < FIFO_MIN_DEPTH) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
  end

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  fifo_flags_t       flags_q, flags_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  fifo_dp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wptr_q),
    .wr_data (din),
    .rd_addr (rptr_q),
    .rd_data (ram_rdata)
  );

  always_comb begin
    // A read frees a slot this cycle, so a write into a full FIFO is still
    // accepted when paired with a read. A read of an empty FIFO is never
    // accepted, even alongside a write.
    rd_acc = rd_en & ~flags_q.empty;
    wr_acc = wr_en & (~flags_q.full | rd_acc);

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) rptr_d = rptr_q + AW'(1);

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags follow the post-edge occupancy so they are correct the cycle
    // after the causing edge.
    flags_d     = fifo_flags_from_count(int'(count_d), DEPTH, AF_LEVEL, AE_LEVEL);
    overflow_d  = wr_en & ~wr_acc;
    underflow_d = rd_en & ~rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      flags_q     <= FIFO_FLAGS_RST;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly from storage; forced to zero while empty
  // so dout reads 0 out of reset.
  assign dout       = flags_q.empty ? '0 : ram_rdata;
  assign dout_valid = ~flags_q.empty;
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  always_comb begin
    dout_d       = rd_acc ? ram_rdata : dout_q;
    dout_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`endif

  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_sync_fifo_param                                             |
// | Purpose   : Scoreboard bench for sync_fifo_param (DATA_W=8, DEPTH=16,      |
// |             AF_LEVEL=14, AE_LEVEL=2). A queue-based reference model        |
// |             predicts per-cycle status and read data; a monitor compares.   |
// |             Follows SYNC_FIFO_FWFT_EN when defined for the build.          |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 14;
  localparam int AE_LEVEL = 2;
  localparam int CW       = fifo_cnt_w(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, full, empty, almost_full, almost_empty;
  logic [CW-1:0]     count;
  logic              overflow, underflow;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  typedef struct {
    int                cnt;
    fifo_flags_t       fl;
    bit                ovf;
    bit                unf;
    bit                dv;
    logic [DATA_W-1:0] dout;
  } stat_t;

  stat_t             stat_q[$];
  logic [DATA_W-1:0] data_q[$];
  logic [DATA_W-1:0] model[$];
  logic [DATA_W-1:0] model_dout = '0;
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides what the FIFO must do from the
  // occupancy rules and queues the expected post-edge state.
  task automatic cyc(input bit do_rst, input bit we, input bit re, input logic [DATA_W-1:0] d);
    stat_t             s;
    bit                rd_ok, wr_ok;
    logic [DATA_W-1:0] h;
    @(negedge clk);
    rst = do_rst; wr_en = we; rd_en = re; din = d;
    s.dv = 1'b0;
    if (do_rst) begin
      model.delete();
      model_dout = '0;
      s.ovf = 1'b0;
      s.unf = 1'b0;
    end else begin
      rd_ok = re && (model.size() > 0);
      wr_ok = we && ((model.size() < DEPTH) || rd_ok);
      s.ovf = we && !wr_ok;
      s.unf = re && !rd_ok;
      if (rd_ok) begin
        h = model.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
        model_dout = h;
        s.dv = 1'b1;
        data_q.push_back(h);
`endif
      end
      if (wr_ok) model.push_back(d);
    end
`ifdef SYNC_FIFO_FWFT_EN
    s.dv = (model.size() > 0);
    model_dout = s.dv ? model[0] : '0;
`endif
    s.cnt             = model.size();
    s.fl.full         = (s.cnt == DEPTH);
    s.fl.empty        = (s.cnt == 0);
    s.fl.almost_full  = (s.cnt >= AF_LEVEL);
    s.fl.almost_empty = (s.cnt <= AE_LEVEL);
    s.dout            = model_dout;
    stat_q.push_back(s);
  endtask

  // Monitor: compares the DUT just after each rising edge.
  initial begin
    stat_t s;
    forever begin
      @(posedge clk);
      #1;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        check("count",        count,        s.cnt);
        check("full",         full,         s.fl.full);
        check("empty",        empty,        s.fl.empty);
        check("almost_full",  almost_full,  s.fl.almost_full);
        check("almost_empty", almost_empty, s.fl.almost_empty);
        check("overflow",     overflow,     s.ovf);
        check("underflow",    underflow,    s.unf);
        check("dout_valid",   dout_valid,   s.dv);
        check("dout",         dout,         s.dout);
`ifndef SYNC_FIFO_FWFT_EN
        if (dout_valid === 1'b1) begin
          if (data_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_data: got %0h expected no read at %0t", dout, $time);
          end else begin
            check("rd_data", dout, data_q.pop_front());
          end
        end
`endif
      end
    end
  end

  initial begin
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);

    // Fill to full, then one rejected write.
    for (int i = 1; i <= 16; i++) cyc(0, 1, 0, DATA_W'(i));
    cyc(0, 1, 0, 8'h11);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, '0);
    cyc(0, 0, 1, '0);

    // Full with simultaneous read+write.
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, DATA_W'($urandom));
    for (int i = 0; i < 4; i++)  cyc(0, 1, 1, 8'hAA);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, '0);

    // Empty with simultaneous read+write, then alternating traffic across wrap.
    cyc(0, 1, 1, 8'h55);
    cyc(0, 0, 1, '0);
    for (int i = 0; i < 40; i++) cyc(0, (i % 2) == 0, (i % 2) == 1, DATA_W'($urandom));

    // Reset in the middle of a write burst, then fresh data.
    for (int i = 0; i < 5; i++) cyc(i == 3, 1, 0, DATA_W'($urandom));
    cyc(0, 1, 0, 8'hC3);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 1, '0);

    // Write into empty, observe, then pop.
    cyc(1, 0, 0, '0);
    cyc(0, 1, 0, 8'h33);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < (i < 300 ? 65 : 40),
          $urandom_range(0, 99) < (i < 300 ? 40 : 65),
          DATA_W'($urandom));
    end

    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    @(posedge clk);
    #2;
    check("stat_queue_drained", stat_q.size(), 0);
    check("data_queue_drained", data_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
